// File: rtl/coffee_order_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// coffee_pkg
// Shared definitions for the coffee order scheduler: the dispatch FSM state
// encoding, the coffee select codes understood by CoffeeFSM, and the engine
// state value that means the brewing engine is idle.
// ---------------------------------------------------------------------------
package coffee_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BREW  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } dispatch_state_t;

    localparam logic [1:0] SEL_ESPRESSO   = 2'b00;
    localparam logic [1:0] SEL_LATTE      = 2'b01;
    localparam logic [1:0] SEL_CAPPUCCINO = 2'b10;
    localparam logic [1:0] SEL_INVALID    = 2'b11;

    localparam logic [2:0] ENG_IDLE = 3'd0;

endpackage

// File: rtl/coffee_order_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// coffee_order_fifo
// Small synchronous FIFO holding admitted orders ({panel id, coffee select}).
// Push and pop may happen in the same cycle; a pop on an empty FIFO is
// ignored, and a push into a full FIFO is only taken when a pop frees the
// head slot in that same cycle.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset (empties the FIFO)
//   push   - write din at the tail
//   pop    - drop the head entry
//   din    - entry to write
//   dout   - current head entry (valid while !empty)
//   full   - DEPTH entries stored
//   empty  - no entries stored
//   count  - number of entries stored
// ---------------------------------------------------------------------------
module coffee_order_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/coffee_order_scheduler.sv
// ---------------------------------------------------------------------------
// coffee_order_scheduler
// Shares one CoffeeFSM brewing engine between N_REQ order panels. A
// round-robin arbiter admits at most one order per cycle into a FIFO, and a
// dispatch FSM starts one brew at a time with a level start request that is
// held until the engine leaves IDLE, so the engine may run on any divided
// clock.
//
// Ports:
//   clk          - fast system clock
//   reset        - asynchronous, active-low reset
//   req          - per-panel order request (level, held until answered)
//   req_sel      - per-panel coffee select, panel i on bits [2i+1:2i]
//   accepted     - pulse: panel's order entered the FIFO
//   rejected     - pulse: panel's order refused (select 2'b11)
//   fsm_start    - start request to CoffeeFSM
//   fsm_sel      - coffee select to CoffeeFSM, only changes in S_IDLE
//   fsm_state    - CoffeeFSM state, 0 = IDLE
//   fsm_done     - CoffeeFSM done
//   served_valid - pulse: brew completed
//   served_id    - panel whose brew completed
//   err_timeout  - pulse: order aborted on start or brew timeout
//   busy         - dispatch FSM not idle
//   queue_count  - FIFO occupancy
// ---------------------------------------------------------------------------
module coffee_order_scheduler
    import coffee_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int QDEPTH   = 4,
    parameter int START_TO = 1024,
    parameter int BREW_TO  = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         req_sel,
    output logic [N_REQ-1:0]           accepted,
    output logic [N_REQ-1:0]           rejected,
    output logic                       fsm_start,
    output logic [1:0]                 fsm_sel,
    input  logic [2:0]                 fsm_state,
    input  logic                       fsm_done,
    output logic                       served_valid,
    output logic [$clog2(N_REQ)-1:0]   served_id,
    output logic                       err_timeout,
    output logic                       busy,
    output logic [$clog2(QDEPTH):0]    queue_count
);

    localparam int IW   = $clog2(N_REQ);
    localparam int EW   = IW + 2;
    localparam int TMAX = (START_TO > BREW_TO) ? START_TO : BREW_TO;
    localparam int TW   = $clog2(TMAX + 1) + 1;

    dispatch_state_t state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick;
    logic            found;
    logic [1:0]      pick_sel;
    logic            arb_blocked;
    logic            take;
    logic            do_reject;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    logic [IW-1:0]   cur_id;
    logic [TW-1:0]   tmo;
    logic            done_seen;

    coffee_order_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({pick, pick_sel}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    assign busy     = (state != S_IDLE);
    assign fifo_pop = (state == S_IDLE) && !fifo_empty && (fsm_state == ENG_IDLE);

    // Round-robin scan: first asserted request at or after the pointer wins.
    // A full FIFO blocks both accept and reject unless the dispatcher pops the
    // head in this same cycle, which frees a slot for the incoming order.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_sel    = req_sel[{pick, 1'b0} +: 2];
        arb_blocked = fifo_full && !fifo_pop;
        take        = found && !arb_blocked;
        do_reject   = take && (pick_sel == SEL_INVALID);
        fifo_push   = take && (pick_sel != SEL_INVALID);
    end

    // Arbiter outputs are registered one-cycle pulses; the pointer only moves
    // past a panel once that panel has been answered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            accepted <= '0;
            rejected <= '0;
        end else begin
            accepted <= '0;
            rejected <= '0;
            if (take) begin
                rr_ptr <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                if (do_reject) begin
                    rejected[pick] <= 1'b1;
                end else begin
                    accepted[pick] <= 1'b1;
                end
            end
        end
    end

    // Dispatch FSM: one brew in flight. The timeout counter restarts on every
    // state entry and saturates rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cur_id       <= '0;
            tmo          <= '0;
            done_seen    <= 1'b0;
            fsm_start    <= 1'b0;
            fsm_sel      <= '0;
            served_valid <= 1'b0;
            served_id    <= '0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo <= '0;
                    if (fifo_pop) begin
                        cur_id    <= fifo_head[EW-1:2];
                        fsm_sel   <= fifo_head[1:0];
                        fsm_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (fsm_state != ENG_IDLE) begin
                        fsm_start <= 1'b0;
                        done_seen <= 1'b0;
                        tmo       <= '0;
                        state     <= S_BREW;
                    end else if (tmo == TW'(START_TO - 1)) begin
                        fsm_start   <= 1'b0;
                        err_timeout <= 1'b1;
                        tmo         <= '0;
                        state       <= S_ABORT;
                    end else if (tmo != '1) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_BREW: begin
                    if (fsm_done) begin
                        done_seen <= 1'b1;
                    end
                    // Engine back in IDLE completes the brew whether or not a
                    // done pulse was observed; done is informational only.
                    if ((fsm_state == ENG_IDLE) && (done_seen || fsm_done)) begin
                        served_valid <= 1'b1;
                        served_id    <= cur_id;
                        tmo          <= '0;
                        state        <= S_DONE;
                    end else if (fsm_state == ENG_IDLE) begin
                        served_valid <= 1'b1;
                        served_id    <= cur_id;
                        tmo          <= '0;
                        state        <= S_DONE;
                    end else if (tmo == TW'(BREW_TO - 1)) begin
                        err_timeout <= 1'b1;
                        tmo         <= '0;
                        state       <= S_ABORT;
                    end else if (tmo != '1) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_DONE: begin
                    served_valid <= 1'b0;
                    tmo          <= '0;
                    state        <= S_IDLE;
                end
                S_ABORT: begin
                    err_timeout <= 1'b0;
                    tmo         <= '0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coffee_order_scheduler.sv
// ---------------------------------------------------------------------------
// tb_coffee_order_scheduler
// Self-checking bench for coffee_order_scheduler. A transaction-level model
// (queue of orders, round-robin index, dispatch phase with a cycle count)
// predicts every output each cycle; a behavioural CoffeeFSM stand-in reacts
// to fsm_start. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_coffee_order_scheduler;

    localparam int N_REQ    = 4;
    localparam int QDEPTH   = 4;
    localparam int START_TO = 16;
    localparam int BREW_TO  = 64;

    localparam int PH_IDLE  = 0;
    localparam int PH_START = 1;
    localparam int PH_BREW  = 2;
    localparam int PH_DONE  = 3;
    localparam int PH_ABORT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] req_sel;
    logic [3:0] accepted;
    logic [3:0] rejected;
    logic       fsm_start;
    logic [1:0] fsm_sel;
    logic [2:0] fsm_state;
    logic       fsm_done;
    logic       served_valid;
    logic [1:0] served_id;
    logic       err_timeout;
    logic       busy;
    logic [2:0] queue_count;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         mQ[$];
    int         mRr;
    int         mPhase;
    int         mCnt;
    int         mCurId;
    logic [3:0] eAcc;
    logic [3:0] eRej;
    logic       eStart;
    logic [1:0] eSel;
    logic       eServed;
    logic [1:0] eServedId;
    logic       eErr;

    // engine stand-in state
    int engRemain;
    int engWait;
    int engLat;
    int engFixLen;
    bit engStuck;
    bit randReq;

    // free-running fast clock
    always #5 clk = ~clk;

    coffee_order_scheduler #(
        .N_REQ    (N_REQ),
        .QDEPTH   (QDEPTH),
        .START_TO (START_TO),
        .BREW_TO  (BREW_TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_sel      (req_sel),
        .accepted     (accepted),
        .rejected     (rejected),
        .fsm_start    (fsm_start),
        .fsm_sel      (fsm_sel),
        .fsm_state    (fsm_state),
        .fsm_done     (fsm_done),
        .served_valid (served_valid),
        .served_id    (served_id),
        .err_timeout  (err_timeout),
        .busy         (busy),
        .queue_count  (queue_count)
    );

    // one comparison, counted, reported on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // compare every DUT output to the model's prediction for this cycle
    task automatic checkAll();
        checkOutput("accepted", 32'(accepted), 32'(eAcc));
        checkOutput("rejected", 32'(rejected), 32'(eRej));
        checkOutput("fsm_start", 32'(fsm_start), 32'(eStart));
        checkOutput("fsm_sel", 32'(fsm_sel), 32'(eSel));
        checkOutput("served_valid", 32'(served_valid), 32'(eServed));
        if (eServed) begin
            checkOutput("served_id", 32'(served_id), 32'(eServedId));
        end
        checkOutput("err_timeout", 32'(err_timeout), 32'(eErr));
        checkOutput("busy", 32'(busy), 32'(mPhase != PH_IDLE));
        checkOutput("queue_count", 32'(queue_count), 32'(mQ.size()));
    endtask

    // put the model back into its power-on state
    task automatic modelReset();
        mQ.delete();
        mRr       = 0;
        mPhase    = PH_IDLE;
        mCnt      = 0;
        mCurId    = 0;
        eAcc      = '0;
        eRej      = '0;
        eStart    = 1'b0;
        eSel      = '0;
        eServed   = 1'b0;
        eServedId = '0;
        eErr      = 1'b0;
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic modelStep();
        bit         popNow;
        bit         blocked;
        int         head;
        int         pick;
        logic [1:0] s;
        popNow  = (mPhase == PH_IDLE) && (mQ.size() > 0) && (fsm_state == 3'd0);
        blocked = (mQ.size() == QDEPTH) && !popNow;
        eAcc    = '0;
        eRej    = '0;
        case (mPhase)
            PH_IDLE: begin
                if (popNow) begin
                    head   = mQ.pop_front();
                    mCurId = head / 4;
                    eSel   = 2'(head % 4);
                    eStart = 1'b1;
                    mCnt   = 0;
                    mPhase = PH_START;
                end
            end
            PH_START: begin
                mCnt++;
                if (fsm_state != 3'd0) begin
                    eStart = 1'b0;
                    mCnt   = 0;
                    mPhase = PH_BREW;
                end else if (mCnt == START_TO) begin
                    eStart = 1'b0;
                    eErr   = 1'b1;
                    mPhase = PH_ABORT;
                end
            end
            PH_BREW: begin
                mCnt++;
                if (fsm_state == 3'd0) begin
                    eServed   = 1'b1;
                    eServedId = 2'(mCurId);
                    mPhase    = PH_DONE;
                end else if (mCnt == BREW_TO) begin
                    eErr   = 1'b1;
                    mPhase = PH_ABORT;
                end
            end
            PH_DONE: begin
                eServed = 1'b0;
                mPhase  = PH_IDLE;
            end
            default: begin
                eErr   = 1'b0;
                mPhase = PH_IDLE;
            end
        endcase
        if (!blocked) begin
            pick = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (pick < 0 && req[(mRr + k) % N_REQ]) begin
                    pick = (mRr + k) % N_REQ;
                end
            end
            if (pick >= 0) begin
                s = req_sel[2*pick +: 2];
                if (s == 2'b11) begin
                    eRej[pick] = 1'b1;
                end else begin
                    mQ.push_back(pick * 4 + int'(s));
                    eAcc[pick] = 1'b1;
                end
                mRr = (pick + 1) % N_REQ;
            end
        end
    endtask

    // behavioural CoffeeFSM: waits a few cycles after start, runs, pulses done
    task automatic engineStep();
        fsm_done = 1'b0;
        if (engRemain > 0) begin
            fsm_state = 3'd2;
            fsm_done  = (engRemain == 1);
            engRemain--;
        end else begin
            fsm_state = 3'd0;
            if (!engStuck && fsm_start) begin
                engWait++;
                if (engWait >= engLat) begin
                    engWait   = 0;
                    engRemain = (engFixLen > 0) ? engFixLen : int'($urandom_range(2, 8));
                    engLat    = int'($urandom_range(1, 3));
                    fsm_state = 3'd1;
                    engRemain--;
                end
            end else begin
                engWait = 0;
            end
        end
    endtask

    // raise an order on one panel; it is held until answered
    task automatic applyStimulus(input int panel, input logic [1:0] sel);
        req[panel]           = 1'b1;
        req_sel[2*panel +: 2] = sel;
    endtask

    // one clock: predict, let the DUT clock, check at the falling edge, react
    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        for (int i = 0; i < N_REQ; i++) begin
            if (eAcc[i] || eRej[i]) begin
                req[i] = 1'b0;
            end
        end
        engineStep();
        if (randReq) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    applyStimulus(i, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
                end
            end
        end
    endtask

    // asynchronous reset between clock edges; outputs must clear at once
    task automatic doReset(input bit clearEngine);
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_accepted", 32'(accepted), 32'h0);
        checkOutput("rst_rejected", 32'(rejected), 32'h0);
        checkOutput("rst_fsm_start", 32'(fsm_start), 32'h0);
        checkOutput("rst_fsm_sel", 32'(fsm_sel), 32'h0);
        checkOutput("rst_served_valid", 32'(served_valid), 32'h0);
        checkOutput("rst_served_id", 32'(served_id), 32'h0);
        checkOutput("rst_err_timeout", 32'(err_timeout), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_queue_count", 32'(queue_count), 32'h0);
        modelReset();
        req = '0;
        if (clearEngine) begin
            engRemain = 0;
            engWait   = 0;
            fsm_state = 3'd0;
            fsm_done  = 1'b0;
        end
        #1 reset = 1'b1;
    endtask

    // directed scenarios followed by a randomized soak, then the summary
    initial begin
        reset     = 1'b0;
        req       = '0;
        req_sel   = '0;
        fsm_state = 3'd0;
        fsm_done  = 1'b0;
        engRemain = 0;
        engWait   = 0;
        engLat    = 1;
        engFixLen = 0;
        engStuck  = 1'b0;
        randReq   = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        #1 reset = 1'b1;

        $display("[TB] single order from panel 2");
        applyStimulus(2, 2'b01);
        repeat (20) tick();

        $display("[TB] contention on panels 0,1,3");
        doReset(1'b1);
        applyStimulus(0, 2'b00);
        applyStimulus(1, 2'b10);
        applyStimulus(3, 2'b01);
        repeat (60) tick();

        $display("[TB] fill the FIFO during a long brew");
        engFixLen = 30;
        applyStimulus(0, 2'b00);
        applyStimulus(1, 2'b01);
        applyStimulus(2, 2'b10);
        applyStimulus(3, 2'b00);
        repeat (6) tick();
        applyStimulus(0, 2'b01);
        applyStimulus(1, 2'b10);
        repeat (200) tick();
        engFixLen = 0;

        $display("[TB] invalid select is rejected");
        applyStimulus(1, 2'b11);
        repeat (5) tick();

        $display("[TB] start timeout with engine stuck idle");
        engStuck = 1'b1;
        applyStimulus(2, 2'b00);
        applyStimulus(3, 2'b01);
        repeat (50) tick();
        engStuck = 1'b0;
        repeat (5) tick();

        $display("[TB] brew timeout with an over-long brew");
        engFixLen = 80;
        applyStimulus(0, 2'b10);
        repeat (100) tick();
        engFixLen = 0;
        repeat (10) tick();

        $display("[TB] asynchronous reset in the middle of a brew");
        engFixLen = 20;
        applyStimulus(1, 2'b01);
        repeat (6) tick();
        doReset(1'b0);
        repeat (30) tick();
        engFixLen = 0;

        $display("[TB] randomized traffic");
        randReq = 1'b1;
        repeat (800) tick();
        randReq = 1'b0;
        repeat (100) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
